muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative multiply/divide engine with HI/LO state for the 5-stage pipeline. It sits in Execute beside the ALU and Shifter.
//  It accepts MulDivFunct_E plus operands rs/rt, runs a 1-bit-per-cycle shift-add multiply or restoring divide, and updates HI/LO.
//  stall_out freezes F/D/E (ORed into Stall_F/Stall_D) while busy, and while an MFHI/MFLO waits on a pending result.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are WIDTH each; iteration counter is $clog2(WIDTH)+1 bits
// PORTS
//  clk        in   1      pipeline clock, rising edge
//  reset      in   1      asynchronous, active-high; clears all state
//  funct      in   3      000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MFHI, 110 MFLO, 111 none
//  valid      in   1      funct/operands qualify this cycle (Execute stage not flushed)
//  rs_value   in   WIDTH  multiplicand / dividend
//  rt_value   in   WIDTH  multiplier / divisor
//  result     out  WIDTH  HI for MFHI, LO for MFLO, else 0 (combinational from registers)
//  hi, lo     out  WIDTH  architectural HI/LO
//  busy       out  1      operation in progress (registered)
//  stall_out  out  1      freeze request to hazard unit (combinational)
//  done       out  1      one-cycle pulse when HI/LO are updated
// BEHAVIOUR
//  Reset (async): state=IDLE; hi=lo=0; busy=0; done=0; counter=0; internal accumulators=0.
//  FSM states: IDLE -> RUN -> FIX -> IDLE.
//   IDLE: valid & funct in {001..100} at a clk edge latches the operands.
//     For signed ops, latch |operand| and the result sign flags.
//     Counter=0, busy=1, go to RUN.
//   RUN: one iteration per cycle for exactly WIDTH cycles, then go to FIX.
//     MUL: if mplier[0], {acc,mplier} = ({acc,mplier} + (mcand<<WIDTH)) >> 1; else shift right only.
//     DIV: restoring; {rem,quo} <<= 1; if rem >= divisor, then rem -= divisor and quo[0]=1.
//   FIX: apply sign correction, write hi/lo, busy=0, done=1 for this edge only, go to IDLE.
//     Signed MULT product = negate the 2*WIDTH product if the signs differ.
//     Signed DIV: quotient negated if signs differ; remainder takes the dividend's sign.
//  Latency: start edge S; hi/lo and done valid after edge S+WIDTH+1 (33 cycles after S for WIDTH=32).
//  stall_out = busy | (state==IDLE & valid & funct in {001..100}) | (busy & valid & funct in {101,110}).
//   This holds the issuing instruction for its first cycle only until the FSM latches it.
//   Operands are held internally; rs/rt may change freely after S.
//  MFHI/MFLO in IDLE: no stall; result = hi or lo in the same cycle.
//  New start while busy: ignored. The hazard unit holds the instruction, so it reissues after done.
//  Divide by zero (rt==0): lo = all ones; hi = dividend (original signed value for DIV). Still takes full latency.
//  Signed overflow (-2^(WIDTH-1) / -1): lo = -2^(WIDTH-1), hi = 0.
//  MULTU/DIVU: operands are treated as unsigned; no sign correction in FIX.
//  valid=0 or funct in {000,111}: no state change, stall_out=0.
//  Reset asserted mid-RUN: immediate abort to IDLE with the reset values; no done pulse.
//  Back-to-back ops: the FIX->IDLE edge accepts nothing. The next start is sampled at the first IDLE edge after done.
// TESTING
//  1. Reset: reset=1 then 0 -> hi=lo=0, busy=0, stall_out=0, result=0 for funct=101.
//  2. MULT rs=-3 (0xFFFFFFFD), rt=7 -> done at S+33.
//     Required: hi=0xFFFFFFFF, lo=0xFFFFFFEB, stall_out high for cycles S..S+32.
//  3. MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  4. DIV rs=-7, rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//     Then DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=100.
//  5. MFLO issued 5 cycles after a MULT start -> stall_out held until done.
//     Required: result=new lo in the cycle after done, with no stale value.
//  6. Reset pulsed at S+10 of a DIV -> busy=0, hi=lo=0, no done pulse.
//     Then a fresh MULT 6*7 -> lo=42, hi=0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative multiply/divide unit that sits in Execute next to the ALU and
//   shifter, and owns the architectural HI/LO registers. MULT/MULTU use a
//   shift-add multiply and DIV/DIVU use a restoring divide. Both retire one
//   bit per cycle. Signed operations run on magnitudes, and the signs are
//   fixed up in a final cycle.
//
//   Timeline for a start accepted at edge S:
//     S          operands latched, busy rises
//     S+1..S+W   one iteration per edge
//     S+W+1      HI/LO written, done pulses
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all state
//   funct      1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 0/7 none
//   valid      funct/operands qualify this cycle
//   rs_value   multiplicand / dividend
//   rt_value   multiplier / divisor
//   result     HI for MFHI, LO for MFLO, else 0 (combinational)
//   hi, lo     architectural HI/LO
//   busy       operation in progress (registered)
//   stall_out  freeze request to the hazard unit (combinational)
//   done       one-cycle pulse when HI/LO are updated
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       funct,
  input  logic             valid,
  input  logic [WIDTH-1:0] rs_value,
  input  logic [WIDTH-1:0] rt_value,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall_out,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   counter;
  logic [WIDTH-1:0] acc;       // product high half / partial remainder
  logic [WIDTH-1:0] low;       // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] opnd;      // multiplicand / divisor magnitude
  logic [WIDTH-1:0] dvd_orig;  // unmodified dividend, returned in HI on divide-by-zero
  logic             is_mul;
  logic             neg_q;     // operand signs differ: negate product/quotient
  logic             neg_r;     // dividend negative: negate remainder
  logic             div0;

  logic             is_start, is_mf, is_sgn, start, a_neg, b_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH-1:0] acc_nx, low_nx;
  logic [WIDTH:0]   sum, rem_sh;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
    mag = neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg2w(input logic [2*WIDTH-1:0] v, input logic neg);
    neg2w = neg ? (~v + 1'b1) : v;
  endfunction

  assign is_start = (funct >= 3'd1) && (funct <= 3'd4);
  assign is_mf    = (funct == 3'd5) || (funct == 3'd6);
  assign is_sgn   = (funct == 3'd1) || (funct == 3'd3);
  assign start    = (state == IDLE) && valid && is_start;
  assign a_neg    = is_sgn && rs_value[WIDTH-1];
  assign b_neg    = is_sgn && rt_value[WIDTH-1];
  assign rs_mag   = mag(rs_value, a_neg);
  assign rt_mag   = mag(rt_value, b_neg);

  // The first cycle of an issuing op stalls until the FSM latches it; an
  // MFHI/MFLO behind a running op stalls until HI/LO are final.
  assign stall_out = busy || start || (busy && valid && is_mf);

  always_comb begin
    result = '0;
    if (funct == 3'd5)      result = hi;
    else if (funct == 3'd6) result = lo;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (counter == CW'(WIDTH - 1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // One iteration: shift-add multiply step or restoring divide step.
  always_comb begin
    sum    = {1'b0, acc} + (low[0] ? {1'b0, opnd} : '0);
    rem_sh = {acc, low[WIDTH-1]};
    acc_nx = acc;
    low_nx = low;
    if (is_mul) begin
      acc_nx = sum[WIDTH:1];
      low_nx = {sum[0], low[WIDTH-1:1]};
    end else if (rem_sh >= {1'b0, opnd}) begin
      // Remainder after subtraction is below the divisor, so the low WIDTH bits suffice.
      acc_nx = rem_sh[WIDTH-1:0] - opnd;
      low_nx = {low[WIDTH-2:0], 1'b1};
    end else begin
      acc_nx = rem_sh[WIDTH-1:0];
      low_nx = {low[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction and special cases applied on the FIX edge.
  always_comb begin
    prod   = neg2w({acc, low}, neg_q);
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (!is_mul) begin
      if (div0) begin
        fix_hi = dvd_orig;
        fix_lo = '1;
      end else begin
        fix_hi = mag(acc, neg_r);
        fix_lo = mag(low, neg_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      counter  <= '0;
      acc      <= '0;
      low      <= '0;
      opnd     <= '0;
      dvd_orig <= '0;
      is_mul   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_mul   <= (funct == 3'd1) || (funct == 3'd2);
            acc      <= '0;
            low      <= (funct <= 3'd2) ? rt_mag : rs_mag;
            opnd     <= (funct <= 3'd2) ? rs_mag : rt_mag;
            dvd_orig <= rs_value;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div0     <= (rt_value == '0);
            counter  <= '0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          acc     <= acc_nx;
          low     <= low_nx;
          counter <= counter + CW'(1);
        end
        FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   funct;
  logic         valid;
  logic [W-1:0] rs_value, rt_value;
  logic [W-1:0] result, hi, lo;
  logic         busy, stall_out, done;

  int checks = 0;
  int passed = 0;
  logic [63:0] sb_q[$];

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .funct(funct), .valid(valid),
    .rs_value(rs_value), .rt_value(rt_value), .result(result),
    .hi(hi), .lo(lo), .busy(busy), .stall_out(stall_out), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint p, sa, sb, q, r;
    logic [63:0] u;
    model = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      3'd1: begin p = sa * sb; model = p; end
      3'd2: begin u = {32'b0, a} * {32'b0, b}; model = u; end
      3'd3: begin
        if (b == 0) model = {a, 32'hFFFF_FFFF};
        else begin q = sa / sb; r = sa % sb; model = {r[31:0], q[31:0]}; end
      end
      3'd4: begin
        if (b == 0) model = {a, 32'hFFFF_FFFF};
        else model = {a % b, a / b};
      end
      default: model = '0;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 32'h0;
      1: pick = 32'hFFFF_FFFF;
      2: pick = 32'h8000_0000;
      3: pick = 32'h1;
      4: pick = 32'h7FFF_FFFF;
      default: pick = $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    logic [63:0] e;
    #1;
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h expected no done", hi, lo);
      end else begin
        e = sb_q.pop_front();
        check("sb_hi", {32'b0, hi}, {32'b0, e[63:32]});
        check("sb_lo", {32'b0, lo}, {32'b0, e[31:0]});
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit expect_done);
    @(negedge clk);
    valid = 1'b1; funct = f; rs_value = a; rt_value = b;
    #1;
    check("stall_issue", {63'b0, stall_out}, 64'd1);
    if (expect_done) sb_q.push_back(model(f, a, b));
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0; funct = 3'd0; rs_value = $urandom; rt_value = $urandom;
  endtask

  // Issue, then wait for done. hold>0 keeps a bogus start request asserted for
  // that many cycles while busy; mf_at>0 issues MFLO at that cycle and keeps it.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input int mf_at);
    logic [63:0] e;
    int n;
    bit ok;
    e = model(f, a, b);
    issue(f, a, b, 1'b1);
    n = 0; ok = 1'b1;
    while (n < 100) begin
      @(posedge clk); #1; n++;
      if (done) break;
      if (!(stall_out && busy)) ok = 1'b0;
      if (hold > 0 && n == 1) begin
        valid = 1'b1; funct = 3'($urandom_range(1, 4)); rs_value = $urandom; rt_value = $urandom;
      end
      if (hold > 0 && n == hold) begin valid = 1'b0; funct = 3'd0; end
      if (mf_at > 0 && n == mf_at) begin valid = 1'b1; funct = 3'd6; end
    end
    check("latency", 64'(n), 64'(W + 1));
    check("stall_while_busy", {63'b0, ok}, 64'd1);
    check("busy_after_done", {63'b0, busy}, 64'd0);
    if (mf_at > 0) begin
      check("mflo_stall_released", {63'b0, stall_out}, 64'd0);
      check("mflo_result", {32'b0, result}, {32'b0, e[31:0]});
    end
    valid = 1'b1; funct = 3'd5; #1;
    check("mfhi_no_stall", {63'b0, stall_out}, 64'd0);
    check("mfhi_result", {32'b0, result}, {32'b0, e[63:32]});
    funct = 3'd6; #1;
    check("mflo_idle_result", {32'b0, result}, {32'b0, e[31:0]});
    valid = 1'b0; funct = 3'd0;
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; funct = 3'd0; rs_value = '0; rt_value = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; funct = 3'd5;
    #1;
    check("rst_hi", {32'b0, hi}, 64'd0);
    check("rst_lo", {32'b0, lo}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_stall", {63'b0, stall_out}, 64'd0);
    check("rst_result", {32'b0, result}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    funct = 3'd0;

    run_op(3'd1, 32'hFFFF_FFFD, 32'd7, 0, 0);            // MULT -3*7
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);    // MULTU max*max
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);            // DIV -7/2
    run_op(3'd4, 32'd100, 32'd0, 0, 0);                  // DIVU by zero
    run_op(3'd3, 32'hFFFF_FFFB, 32'd0, 0, 0);            // DIV by zero, signed dividend
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);    // signed overflow
    run_op(3'd1, 32'd123456, 32'hFFFF_FF00, 0, 5);       // MFLO waiting on MULT
    run_op(3'd2, 32'h1234_5678, 32'h9ABC_DEF0, 12, 0);   // start request while busy is ignored

    // Reset in the middle of a divide: abort, no done pulse.
    issue(3'd3, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_hi", {32'b0, hi}, 64'd0);
    check("abort_lo", {32'b0, lo}, 64'd0);
    check("abort_done", {63'b0, done}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(posedge clk);
    run_op(3'd1, 32'd6, 32'd7, 0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(1, 4)), pick(), pick(),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 20)) : 0, 0);
    end

    repeat (5) @(posedge clk);
    #2;
    check("queue_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
